// File: rtl/ir_pkg.sv
// Instruction-register package: field geometry, packed field bundle and a
// reference decode for the default 16-bit word / 6-bit opcode encoding.
package ir_pkg;

  localparam int unsigned IR_IW     = 16;
  localparam int unsigned IR_OPW    = 6;
  localparam int unsigned IR_RA_BIT = IR_IW - IR_OPW - 1;
  localparam int unsigned IR_BAW    = IR_IW - IR_OPW;
  localparam int unsigned IR_IMMW   = IR_IW - IR_OPW - 1;

  // Decoded view of one instruction word; ra/ra_stack/imm overlap ba.
  typedef struct packed {
    logic [IR_OPW-1:0]  opcode;
    logic               ra;
    logic [1:0]         ra_stack;
    logic [IR_BAW-1:0]  ba;
    logic [IR_IMMW-1:0] imm;
  } ir_fields_t;

  localparam ir_fields_t IR_FIELDS_ZERO = '0;

  // Slice a default-width word into its fields.
  function automatic ir_fields_t ir_decode(input logic [IR_IW-1:0] w);
    ir_fields_t f;
    f          = IR_FIELDS_ZERO;
    f.opcode   = w[IR_IW-1 -: IR_OPW];
    f.ra       = w[IR_RA_BIT];
    f.ra_stack = w[IR_RA_BIT -: 2];
    f.ba       = w[IR_BAW-1:0];
    f.imm      = w[IR_IMMW-1:0];
    return f;
  endfunction

endpackage

// File: rtl/ir_field_decode.sv
// Combinational instruction field slicer, shared by the prefetch queue and
// the control FSM. Fields overlap by design (ra, ra_stack, imm all sit in ba).
module ir_field_decode #(
  parameter int unsigned IW  = 16,
  parameter int unsigned OPW = 6
) (
  input  logic [IW-1:0]     word,
  output logic [OPW-1:0]    opcode,
  output logic              ra,
  output logic [1:0]        ra_stack,
  output logic [IW-OPW-1:0] ba,
  output logic [IW-OPW-2:0] imm
);

  // Pure bit slicing of the word.
  always_comb begin
    opcode   = word[IW-1 -: OPW];
    ra       = word[IW-OPW-1];
    ra_stack = word[IW-OPW-1 -: 2];
    ba       = word[IW-OPW-1:0];
    imm      = word[IW-OPW-2:0];
  end

endmodule

// File: rtl/ir_prefetch_queue.sv
// DEPTH-entry instruction prefetch queue with valid/ready on both sides and
// field decode of the head entry. State updates on the falling clock edge.
// Optional macro IRQ_BYPASS_EN: an empty queue forwards in_data straight to
// the head outputs and can hand it over without writing it.
module ir_prefetch_queue
  import ir_pkg::*;
#(
  parameter int unsigned IW    = IR_IW,
  parameter int unsigned OPW   = IR_OPW,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  input  logic [IW-1:0]            in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [IW-1:0]            out,
  output logic [OPW-1:0]           opcode,
  output logic                     ra,
  output logic [1:0]               ra_stack,
  output logic [IW-OPW-1:0]        ba,
  output logic [IW-OPW-2:0]        imm,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [IW-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic          nonempty;
  logic          byp;
  logic          take;
  logic          push;
  logic          pop;
  logic [IW-1:0] head;

  // Handshake qualification and head selection; head is zero when nothing is valid.
  always_comb begin
    nonempty  = (count != '0);
    in_ready  = (count != CW'(DEPTH));
`ifdef IRQ_BYPASS_EN
    byp       = !nonempty && in_valid;
`else
    byp       = 1'b0;
`endif
    out_valid = nonempty | byp;
    take      = byp & out_ready;
    push      = in_valid & in_ready & ~take;
    pop       = nonempty & out_ready;
    head      = '0;
    if (nonempty)
      head = mem[rd_ptr];
    else if (byp)
      head = in_data;
    out       = head;
  end

  // Queue body: pointers wrap naturally at power-of-two DEPTH; flush beats push/pop.
  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        mem[wr_ptr] <= in_data;
        wr_ptr      <= wr_ptr + AW'(1);
      end
      if (pop)
        rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  ir_field_decode #(
    .IW  (IW),
    .OPW (OPW)
  ) u_decode (
    .word     (head),
    .opcode   (opcode),
    .ra       (ra),
    .ra_stack (ra_stack),
    .ba       (ba),
    .imm      (imm)
  );

endmodule

// File: tb/tb_ir_prefetch_queue.sv
// Bench for ir_prefetch_queue: directed scenarios then random traffic, all
// compared against a queue-based model of the prefetch behaviour.
module tb_ir_prefetch_queue;

  localparam int unsigned DEPTH = 4;

  logic        clk;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] in_data;
  logic        in_ready;
  logic        out_valid;
  logic        out_ready;
  logic [15:0] out;
  logic [5:0]  opcode;
  logic        ra;
  logic [1:0]  ra_stack;
  logic [9:0]  ba;
  logic [8:0]  imm;
  logic [2:0]  count;

  int vectors;
  int miscompares;
  logic [15:0] q[$];

`ifdef IRQ_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  ir_prefetch_queue #(.IW(16), .OPW(6), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out       (out),
    .opcode    (opcode),
    .ra        (ra),
    .ra_stack  (ra_stack),
    .ba        (ba),
    .imm       (imm),
    .count     (count)
  );

  initial clk = 1'b1;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model view of the head: queue front, else (bypass) the incoming word, else zero.
  function automatic logic [15:0] exp_head();
    if (q.size() > 0) return q[0];
    if (BYPASS && in_valid) return in_data;
    return 16'h0;
  endfunction

  function automatic logic exp_valid();
    return (q.size() > 0) || (BYPASS && in_valid);
  endfunction

  task automatic check_all(input string tag);
    logic [15:0] w;
    w = exp_head();
    chk({tag, ".count"},    32'(count),     32'(q.size()));
    chk({tag, ".in_ready"}, 32'(in_ready),  32'(q.size() != DEPTH));
    chk({tag, ".valid"},    32'(out_valid), 32'(exp_valid()));
    chk({tag, ".out"},      32'(out),       32'(w));
    chk({tag, ".opcode"},   32'(opcode),    32'(w) / 1024);
    chk({tag, ".ra"},       32'(ra),        (32'(w) / 512) % 2);
    chk({tag, ".ra_stack"}, 32'(ra_stack),  (32'(w) / 256) % 4);
    chk({tag, ".ba"},       32'(ba),        32'(w) % 1024);
    chk({tag, ".imm"},      32'(imm),       32'(w) % 512);
  endtask

  // One falling edge: apply the handshake rules to the model, then check outputs.
  task automatic tick(input string tag);
    bit full;
    bit take;
    full = (q.size() == DEPTH);
    take = BYPASS && (q.size() == 0) && in_valid && out_ready;
    @(negedge clk);
    if (flush) q.delete();
    else if (!take) begin
      bit do_push;
      do_push = in_valid && !full;
      if (out_ready && q.size() > 0) void'(q.pop_front());
      if (do_push) q.push_back(in_data);
    end
    #1;
    check_all(tag);
  endtask

  task automatic drive(input bit v, input logic [15:0] d, input bit r, input bit f);
    in_valid  = v;
    in_data   = d;
    out_ready = r;
    flush     = f;
  endtask

  initial begin
    logic [15:0] words [3];
    vectors     = 0;
    miscompares = 0;
    rst = 1'b0;
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    #12;
    check_all("reset");
    rst = 1'b1;

    // 1: reset in the middle of filling
    words[0] = 16'h0401; words[1] = 16'h0802; words[2] = 16'h0C03;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, words[i], 1'b0, 1'b0);
      tick("fill3");
    end
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    q.delete();
    #1;
    check_all("midreset");
    chk("midreset.count0", 32'(count), 32'd0);
    rst = 1'b1;

    // 2: fill to full, offered fifth word is not stored, then drain in order
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 16'(16'h1100 + i), 1'b0, 1'b0);
      tick("fill4");
    end
    chk("full.in_ready", 32'(in_ready), 32'd0);
    drive(1'b1, 16'hDEAD, 1'b0, 1'b0);
    tick("full5");
    drive(1'b1, 16'hBEEF, 1'b1, 1'b0);
    tick("full_pop_push");
    chk("full_pop_push.count", 32'(count), 32'd3);
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 16'h0, 1'b1, 1'b0);
      tick("drain");
    end
    chk("drained.valid", 32'(out_valid), 32'd0);

    // 3: field decode of a known word
    drive(1'b1, 16'hFE05, 1'b0, 1'b0);
    tick("decode");
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    chk("dec.opcode",   32'(opcode),   32'h3F);
    chk("dec.ra",       32'(ra),       32'd1);
    chk("dec.ra_stack", 32'(ra_stack), 32'd2);
    chk("dec.ba",       32'(ba),       32'h205);
    chk("dec.imm",      32'(imm),      32'h005);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick("dec_pop");

    // 4: steady push/pop at count 2 across pointer wrap
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 16'($urandom), 1'b0, 1'b0);
      tick("pp_pre");
    end
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 16'($urandom), 1'b1, 1'b0);
      tick("pp");
      chk("pp.count2", 32'(count), 32'd2);
    end

    // 5: flush with a concurrent push at count 3
    drive(1'b1, 16'h7777, 1'b0, 1'b0);
    tick("pre_flush");
    drive(1'b1, 16'h5A5A, 1'b0, 1'b1);
    tick("flush");
    drive(1'b0, 16'h0, 1'b0, 1'b0);
    #1;
    chk("flush.count", 32'(count), 32'd0);
    chk("flush.valid", 32'(out_valid), 32'd0);

    // 6: empty queue, word offered and consumed in the same cycle
    drive(1'b1, 16'h1234, 1'b1, 1'b0);
    #1;
    chk("byp.valid_pre", 32'(out_valid), 32'(BYPASS));
    chk("byp.out_pre", 32'(out), BYPASS ? 32'h1234 : 32'h0);
    tick("byp");
    chk("byp.count", 32'(count), BYPASS ? 32'd0 : 32'd1);
    drive(1'b0, 16'h0, 1'b1, 1'b0);
    tick("byp_post");

    // Random traffic
    for (int i = 0; i < 400; i++) begin
      drive(($urandom % 4) != 0, 16'($urandom), ($urandom % 3) != 0, ($urandom % 32) == 0);
      tick("rand");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
